jtopl_mmr: RTL
==============

# jtopl_mmr

CPU-side register interface for the OPL core. It decodes the 2-port bus (address latch and data port) into per-slot and per-channel update requests for the operator/channel register file, and holds each request for one full 18-slot rotation so the rotating slot counter can capture it. It also owns timer 1 and timer 2, the status byte, the IRQ output and the global control bits. It sits directly upstream of the register file and drives its `write`, `sel_group`, `sel_sub` and `up_*` inputs.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cen`  in  1  clock enable; slot rate.
- `din`  in  8  CPU data bus.
- `addr`  in  1  0 = address port, 1 = data port.
- `cs_n`, `wr_n`  in  1 each  bus strobes, active low.
- `zero`  in  1  slot-0 marker from the register file.
- `dout`  out  8  status: {irq, flag_a, flag_b, 5'b0}.
- `irq_n`  out  1  active-low interrupt.
- `busy`  out  1  an update request is being held.
- `write`  out  1  one-clk pulse on a data-port write.
- `sel_group`  out  2  target group.
- `sel_sub`  out  3  target subslot.
- `up_mult`, `up_ksl_tl`, `up_ar_dr`, `up_sl_rr`, `up_fnumlo`, `up_fnumhi`, `up_fbcon`, `up_wav`  out  1 each  held update strobes.
- `data`  out  8  latched write data, held with the strobes.
- `csm`, `nts`, `am_dep`, `vib_dep`, `wav_en`  out  1 each  global control bits.

## Operation
- Bus write strobe:
  - Asserted on the first `clk` where `!cs_n && !wr_n` after a clk with the strobe inactive.
  - Edge is detected from a registered copy of the strobe.
  - Level-held strobes produce exactly one write.
- Address-port write: `sel_reg <= din`.
- Data-port write: `data <= din`, then decode `sel_reg`:
  - `0x01`: `wav_en = din[5]`.
  - `0x02`: timer 1 value. `0x03`: timer 2 value.
  - `0x04`:
    - If `din[7] = 1`: clear `flag_a` and `flag_b`; no other bit of `0x04` changes.
    - Otherwise: `mask_a = din[6]`, `mask_b = din[5]`, `st_b = din[1]`, `st_a = din[0]`.
  - `0x08`: `csm = din[7]`, `nts = din[6]`.
  - `0xBD`: `am_dep = din[7]`, `vib_dep = din[6]`.
  - Operator ranges `0x20`/`0x40`/`0x60`/`0x80`/`0xE0` + offset, with offset in 0..0x15:
    - `sel_group = offset[4:3]`, `sel_sub = offset[2:0]`.
    - Offsets with `offset[2:0] > 5` or `offset[4:3] = 3` are ignored.
    - Assert `up_mult` / `up_ksl_tl` / `up_ar_dr` / `up_sl_rr` / `up_wav` respectively.
  - Channel ranges `0xA0`/`0xB0`/`0xC0` + ch, with ch in 0..8:
    - `sel_group = ch/3`, `sel_sub = ch%3`.
    - Assert `up_fnumlo` / `up_fnumhi` / `up_fbcon`.
    - ch > 8 is ignored.
  - Unmapped addresses are ignored.
- Update hold sequence (operator and channel writes only):
  - `write` pulses for 1 clk.
  - The selected `up_*` strobe, `sel_*` and `data` are held while a 5-bit counter counts 18 `cen` pulses.
  - Then all `up_*` return to 0 and `busy` drops.
  - A new data write while busy aborts the hold and restarts it with the new target; the earlier update may be lost. Software polls `busy`.
- Timers:
  - A prescaler counts `zero && cen` events and is free-running from reset.
  - Timer 1 ticks every 4 samples; timer 2 every 16.
  - On `st_x` rising, the counter loads its value register. While `st_x = 0` the counter holds.
  - On each tick, count +1. At 0xFF it reloads the value and sets `flag_x` unless `mask_x = 1`.
  - Writing `st_x = 0` does not clear the flag.
- `irq = flag_a | flag_b`; `irq_n = !irq`. `dout` is always status; reads are side-effect free.

## Timing
- Reset values:
  - All outputs 0, except `irq_n = 1`.
  - `sel_reg = 0`, timers stopped, value registers 0, prescaler 0.
- Control/global register writes take effect the clk after the strobe edge.
- `write` is high exactly the clk after the edge. `up_*` rise in the same clk and stay high for 18 `cen` pulses.
- `busy` covers exactly the interval in which `up_*` are high.
- A flag sets the clk after the overflowing tick; `irq_n` falls in that same clk.
- Simultaneous overflow and IRQ-reset write: the reset wins for that clk; the next overflow sets the flag again.
- `rst_n` low mid-hold clears strobes and counters immediately (asynchronous).

## Structure
- Shared package holds:
  - register address constants: `TIMER1`, `TIMER2`, `TIMER_CTL`, `CSM_NTS`, `RHYTHM`, `WAVE_EN`, and the range bases;
  - the slot-rotation length 18;
  - the prescaler ratios 4 and 16.
- One sub-module, `jtopl_timer`, instantiated twice; parameter = prescaler divide. It holds the load, count, flag and mask logic.

## Test plan
- Write addr `0x43`, data `0x3F` -> `write` pulse; `up_ksl_tl = 1`, `sel_group = 0`, `sel_sub = 3`, `data = 0x3F` for 18 `cen`; then `busy = 0`.
- Write `0xB5 <= 0x2A` -> `up_fnumhi`, `sel_group = 1`, `sel_sub = 2`. Write to `0x26` and to `0xA9` -> no strobe, `busy` stays 0.
- Write `0x02 <= 0xFE`, `0x04 <= 0x01` -> after 2 timer-1 ticks (8 samples), `dout = 0xC0` and `irq_n = 0`. Write `0x04 <= 0x80` -> `dout = 0x00`.
- Write `0x03 <= 0xFF` with `mask_b = 1`, start -> counter reloads every 16 samples; flag never set; `irq_n` stays 1.
- Hold `cs_n`/`wr_n` low for 10 clk on the data port -> exactly one `write` pulse. A second write at count 9 restarts the hold with the new `sel`.
- Assert `rst_n` low at count 7 of a hold -> all `up_*`, `busy` and `write` are 0 immediately; status is 0x00.

Source files
------------

// File: rtl/jtopl_mmr_pkg.sv
// Shared constants, types and address decode for the OPL CPU register interface.
package jtopl_mmr_pkg;

  localparam logic [7:0] WAVE_EN   = 8'h01;
  localparam logic [7:0] TIMER1    = 8'h02;
  localparam logic [7:0] TIMER2    = 8'h03;
  localparam logic [7:0] TIMER_CTL = 8'h04;
  localparam logic [7:0] CSM_NTS   = 8'h08;
  localparam logic [7:0] RHYTHM    = 8'hBD;

  localparam logic [7:0] OP_MULT   = 8'h20;
  localparam logic [7:0] OP_KSL_TL = 8'h40;
  localparam logic [7:0] OP_AR_DR  = 8'h60;
  localparam logic [7:0] OP_SL_RR  = 8'h80;
  localparam logic [7:0] OP_WAV    = 8'hE0;
  localparam logic [7:0] CH_FNUMLO = 8'hA0;
  localparam logic [7:0] CH_FNUMHI = 8'hB0;
  localparam logic [7:0] CH_FBCON  = 8'hC0;

  localparam int unsigned SLOT_ROT   = 18;
  localparam int unsigned PRESCALE_A = 4;
  localparam int unsigned PRESCALE_B = 16;

  typedef enum logic [3:0] {
    UpNone, UpMult, UpKslTl, UpArDr, UpSlRr, UpFnumLo, UpFnumHi, UpFbcon, UpWav
  } upd_kind_e;

  typedef enum logic {StIdle, StHold} hold_st_e;

  typedef struct packed {
    upd_kind_e   kind;
    logic [1:0]  group;
    logic [2:0]  sub;
  } upd_t;

  // Operator ranges use the top 3 address bits; channel ranges the top nibble.
  function automatic upd_t decode_upd(input logic [7:0] a);
    upd_t       r;
    logic [3:0] ch;
    r  = '{kind: UpNone, group: 2'd0, sub: 3'd0};
    ch = a[3:0];
    if (a[2:0] <= 3'd5 && a[4:3] != 2'd3) begin
      case (a[7:5])
        OP_MULT[7:5]:   r.kind = UpMult;
        OP_KSL_TL[7:5]: r.kind = UpKslTl;
        OP_AR_DR[7:5]:  r.kind = UpArDr;
        OP_SL_RR[7:5]:  r.kind = UpSlRr;
        OP_WAV[7:5]:    r.kind = UpWav;
        default:        r.kind = UpNone;
      endcase
      if (r.kind != UpNone) begin
        r.group = a[4:3];
        r.sub   = a[2:0];
      end
    end
    if (ch <= 4'd8) begin
      case (a[7:4])
        CH_FNUMLO[7:4]: r.kind = UpFnumLo;
        CH_FNUMHI[7:4]: r.kind = UpFnumHi;
        CH_FBCON[7:4]:  r.kind = UpFbcon;
        default:        ;
      endcase
      if (r.kind == UpFnumLo || r.kind == UpFnumHi || r.kind == UpFbcon) begin
        if (ch >= 4'd6) begin
          r.group = 2'd2;
          r.sub   = 3'(ch - 4'd6);
        end else if (ch >= 4'd3) begin
          r.group = 2'd1;
          r.sub   = 3'(ch - 4'd3);
        end else begin
          r.group = 2'd0;
          r.sub   = ch[2:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/jtopl_timer.sv
// One OPL timer: load on start rising, count on prescaled ticks, flag on overflow.
module jtopl_timer #(
  parameter int unsigned Div = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample,
  input  logic [3:0] presc,
  input  logic [7:0] value,
  input  logic       start,
  input  logic       mask,
  input  logic       clr_flag,
  output logic       flag
);

  localparam logic [3:0] PhaseLast = 4'(Div - 1);

  logic       tick;
  logic       ovf;
  logic       start_q;
  logic       flag_q;
  logic [7:0] cnt_q;

  // The prescaler is shared; this timer ticks on the last phase of its divide.
  assign tick = sample && ((presc & PhaseLast) == PhaseLast);
  assign ovf  = start && start_q && tick && (cnt_q == 8'hFF);
  assign flag = flag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      cnt_q   <= 8'd0;
      flag_q  <= 1'b0;
    end else begin
      start_q <= start;
      if (start && !start_q) begin
        cnt_q <= value;
      end else if (start && tick) begin
        cnt_q <= ovf ? value : cnt_q + 8'd1;
      end
      // A flag clear coinciding with overflow wins for that clock.
      if (clr_flag) begin
        flag_q <= 1'b0;
      end else if (ovf && !mask) begin
        flag_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtopl_mmr.sv
// OPL CPU bus decode: global/timer registers and held slot/channel update requests.
module jtopl_mmr
  import jtopl_mmr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic [7:0] din,
  input  logic       addr,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       zero,
  output logic [7:0] dout,
  output logic       irq_n,
  output logic       busy,
  output logic       write,
  output logic [1:0] sel_group,
  output logic [2:0] sel_sub,
  output logic       up_mult,
  output logic       up_ksl_tl,
  output logic       up_ar_dr,
  output logic       up_sl_rr,
  output logic       up_fnumlo,
  output logic       up_fnumhi,
  output logic       up_fbcon,
  output logic       up_wav,
  output logic [7:0] data,
  output logic       csm,
  output logic       nts,
  output logic       am_dep,
  output logic       vib_dep,
  output logic       wav_en
);

  localparam logic [4:0] HoldLast = 5'(SLOT_ROT - 1);

  logic       strobe, strobe_q, we, addr_we, data_we;
  logic       upd_start, clr_flags, sample;
  upd_t       upd;
  logic [7:0] sel_reg_q, data_q, val_a_q, val_b_q;
  logic [1:0] sel_group_q;
  logic [2:0] sel_sub_q;
  upd_kind_e  kind_q;
  logic       write_q;
  logic       st_a_q, st_b_q, mask_a_q, mask_b_q;
  logic       csm_q, nts_q, am_q, vib_q, wav_en_q;
  logic [3:0] presc_q;
  logic [4:0] hold_cnt_q;
  hold_st_e   state_q, state_d;
  logic       flag_a, flag_b, irq;

  assign strobe    = !cs_n && !wr_n;
  assign we        = strobe && !strobe_q;
  assign addr_we   = we && !addr;
  assign data_we   = we && addr;
  assign upd       = decode_upd(sel_reg_q);
  assign upd_start = data_we && (upd.kind != UpNone);
  assign clr_flags = data_we && (sel_reg_q == TIMER_CTL) && din[7];
  assign sample    = zero && cen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q    <= 1'b0;
      write_q     <= 1'b0;
      sel_reg_q   <= 8'd0;
      data_q      <= 8'd0;
      val_a_q     <= 8'd0;
      val_b_q     <= 8'd0;
      st_a_q      <= 1'b0;
      st_b_q      <= 1'b0;
      mask_a_q    <= 1'b0;
      mask_b_q    <= 1'b0;
      csm_q       <= 1'b0;
      nts_q       <= 1'b0;
      am_q        <= 1'b0;
      vib_q       <= 1'b0;
      wav_en_q    <= 1'b0;
      sel_group_q <= 2'd0;
      sel_sub_q   <= 3'd0;
      kind_q      <= UpNone;
      presc_q     <= 4'd0;
    end else begin
      strobe_q <= strobe;
      write_q  <= data_we;
      if (sample) presc_q <= presc_q + 4'd1;
      if (addr_we) sel_reg_q <= din;
      if (data_we) begin
        data_q <= din;
        case (sel_reg_q)
          WAVE_EN: wav_en_q <= din[5];
          TIMER1:  val_a_q  <= din;
          TIMER2:  val_b_q  <= din;
          TIMER_CTL: begin
            if (!din[7]) begin
              mask_a_q <= din[6];
              mask_b_q <= din[5];
              st_b_q   <= din[1];
              st_a_q   <= din[0];
            end
          end
          CSM_NTS: begin
            csm_q <= din[7];
            nts_q <= din[6];
          end
          RHYTHM: begin
            am_q  <= din[7];
            vib_q <= din[6];
          end
          default: ;
        endcase
      end
      if (upd_start) begin
        sel_group_q <= upd.group;
        sel_sub_q   <= upd.sub;
        kind_q      <= upd.kind;
      end
    end
  end

  // Hold FSM: keeps the request up for a full slot rotation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hold_cnt_q <= 5'd0;
    end else begin
      state_q <= state_d;
      if (upd_start) begin
        hold_cnt_q <= 5'd0;
      end else if (state_q == StHold && cen) begin
        hold_cnt_q <= hold_cnt_q + 5'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (upd_start) state_d = StHold;
      StHold: begin
        if (upd_start) begin
          state_d = StHold;
        end else if (cen && hold_cnt_q == HoldLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q == StHold);
    up_mult   = 1'b0;
    up_ksl_tl = 1'b0;
    up_ar_dr  = 1'b0;
    up_sl_rr  = 1'b0;
    up_fnumlo = 1'b0;
    up_fnumhi = 1'b0;
    up_fbcon  = 1'b0;
    up_wav    = 1'b0;
    if (busy) begin
      case (kind_q)
        UpMult:   up_mult   = 1'b1;
        UpKslTl:  up_ksl_tl = 1'b1;
        UpArDr:   up_ar_dr  = 1'b1;
        UpSlRr:   up_sl_rr  = 1'b1;
        UpFnumLo: up_fnumlo = 1'b1;
        UpFnumHi: up_fnumhi = 1'b1;
        UpFbcon:  up_fbcon  = 1'b1;
        UpWav:    up_wav    = 1'b1;
        default:  ;
      endcase
    end
  end

  jtopl_timer #(.Div(PRESCALE_A)) u_timer_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample   (sample),
    .presc    (presc_q),
    .value    (val_a_q),
    .start    (st_a_q),
    .mask     (mask_a_q),
    .clr_flag (clr_flags),
    .flag     (flag_a)
  );

  jtopl_timer #(.Div(PRESCALE_B)) u_timer_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample   (sample),
    .presc    (presc_q),
    .value    (val_b_q),
    .start    (st_b_q),
    .mask     (mask_b_q),
    .clr_flag (clr_flags),
    .flag     (flag_b)
  );

  assign irq       = flag_a | flag_b;
  assign irq_n     = !irq;
  assign dout      = {irq, flag_a, flag_b, 5'b0};
  assign write     = write_q;
  assign sel_group = sel_group_q;
  assign sel_sub   = sel_sub_q;
  assign data      = data_q;
  assign csm       = csm_q;
  assign nts       = nts_q;
  assign am_dep    = am_q;
  assign vib_dep   = vib_q;
  assign wav_en    = wav_en_q;

endmodule
